// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: sole owner of both FIFO ports on the UART -> FIFO -> UART byte path.
// Received bytes are written into the FIFO, or counted as drops when it is full.
// Bytes are read back out for transmit once a full line is queued, once the
// FIFO reaches the high-water mark, or while Flush is held high.
module uart_fifo_ctrl #(
  parameter int                   DataWidth  = 8,
  parameter int                   CountWidth = 10,
  parameter logic [DataWidth-1:0] FlushChar  = 8'h0D,
  parameter int                   HighWater  = 896,
  parameter int                   LineMode   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic [DataWidth-1:0]  RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic [DataWidth-1:0]  FifoDin,
  output logic                  FifoWrEn,
  input  logic                  FifoFull,
  input  logic [CountWidth-1:0] FifoCount,
  output logic                  FifoRdEn,
  input  logic [DataWidth-1:0]  FifoDout,
  input  logic                  FifoValid,
  input  logic                  FifoEmpty,
  output logic [DataWidth-1:0]  TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic [7:0]            DropCount,
  output logic [CountWidth-1:0] LineCount
);

  localparam logic [CountWidth-1:0] HIGH_WATER = CountWidth'(HighWater);
  localparam bit                    FREE_RUN   = (LineMode == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t state, state_next;
  logic   rd_en_next;
  logic   tx_valid_next;
  logic   tx_load;

  logic   rx_accept;
  logic   line_inc;
  logic   line_dec;
  logic   go;

  assign rx_accept = RxValid && RxReady;

  // A line terminator counts on the edge that schedules its write, so LineCount
  // and FifoWrEn rise together for that byte.
  assign line_inc  = rx_accept && !FifoFull && (RxData == FlushChar);
  assign line_dec  = TxValid && TxReady && (TxData == FlushChar);

  assign go = !FifoEmpty &&
              (FREE_RUN || (LineCount != '0) || (FifoCount >= HIGH_WATER) || Flush);

  // Write path: always ready after reset, register one write per accepted byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RxReady   <= 1'b0;
      FifoWrEn  <= 1'b0;
      FifoDin   <= '0;
      DropCount <= '0;
    end else begin
      RxReady  <= 1'b1;
      FifoWrEn <= 1'b0;
      if (rx_accept) begin
        if (!FifoFull) begin
          FifoWrEn <= 1'b1;
          FifoDin  <= RxData;
        end else if (DropCount != 8'hFF) begin
          DropCount <= DropCount + 8'd1;
        end
      end
    end
  end

  // Line counter: saturating up, floored at zero, simultaneous inc/dec cancel.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      LineCount <= '0;
    end else begin
      unique case ({line_inc, line_dec})
        2'b10: if (LineCount != '1) LineCount <= LineCount + 1'b1;
        2'b01: if (LineCount != '0) LineCount <= LineCount - 1'b1;
        default: ;
      endcase
    end
  end

  // Read FSM state and registered read/transmit outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      FifoRdEn <= 1'b0;
      TxValid  <= 1'b0;
      TxData   <= '0;
    end else begin
      state    <= state_next;
      FifoRdEn <= rd_en_next;
      TxValid  <= tx_valid_next;
      if (tx_load) TxData <= FifoDout;
    end
  end

  // Read FSM next state: one read outstanding, data held until handshake.
  always_comb begin
    state_next    = state;
    rd_en_next    = 1'b0;
    tx_valid_next = TxValid;
    tx_load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          rd_en_next = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (FifoValid) begin
          tx_load       = 1'b1;
          tx_valid_next = 1'b1;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (TxReady) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        tx_valid_next = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

endmodule
